// File: rtl/spart_key_rx.sv
// spart_key_rx: 8N1 serial receiver feeding the CPU's SPART key strobe.
// Mapped key bytes become a 4-bit code with a one-cycle write pulse.
module spart_key_rx #(
  parameter int unsigned DIVISOR = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       SPART_we,
  output logic [3:0] SPART_keys,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       rx_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  localparam logic [15:0] HALF = 16'(DIVISOR / 2 - 1);
  localparam logic [15:0] FULL = 16'(DIVISOR - 1);

  state_t      r_state;
  logic        r_sync1;
  logic        r_rxd_s;
  logic [15:0] r_bcnt;
  logic [2:0]  r_bidx;
  logic [7:0]  r_shift;
  logic        w_mapped;
  logic [3:0]  w_code;

  always_comb begin
    w_mapped = 1'b1;
    w_code   = 4'h0;
    unique case (r_shift)
      8'h77, 8'h57: w_code = 4'h1;
      8'h73, 8'h53: w_code = 4'h2;
      8'h61, 8'h41: w_code = 4'h4;
      8'h64, 8'h44: w_code = 4'h8;
      8'h20:        w_code = 4'hF;
      default:      w_mapped = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_bcnt     <= '0;
      r_bidx     <= '0;
      r_shift    <= '0;
      SPART_we   <= 1'b0;
      SPART_keys <= 4'h0;
      rx_byte    <= 8'h00;
      rx_vld     <= 1'b0;
      rx_err     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_sync1  <= rxd;
      r_rxd_s  <= r_sync1;
      SPART_we <= 1'b0;
      rx_vld   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!r_rxd_s) begin
            r_bcnt  <= HALF;
            r_state <= S_START;
            busy    <= 1'b1;
          end
        end
        S_START: begin
          if (r_bcnt != 16'd0) begin
            r_bcnt <= r_bcnt - 16'd1;
          end else if (r_rxd_s) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_bcnt  <= FULL;
            r_bidx  <= 3'd0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_bcnt != 16'd0) begin
            r_bcnt <= r_bcnt - 16'd1;
          end else begin
            r_shift <= {r_rxd_s, r_shift[7:1]};
            r_bcnt  <= FULL;
            r_bidx  <= r_bidx + 3'd1;
            if (r_bidx == 3'd7) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (r_bcnt != 16'd0) begin
            r_bcnt <= r_bcnt - 16'd1;
          end else if (r_rxd_s) begin
            rx_byte <= r_shift;
            rx_vld  <= 1'b1;
            rx_err  <= 1'b0;
            if (w_mapped) begin
              SPART_we   <= 1'b1;
              SPART_keys <= w_code;
            end
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            rx_err  <= 1'b1;
            r_state <= S_BRK;
          end
        end
        S_BRK: begin
          // Hold off start detection until the line returns to idle.
          if (r_rxd_s) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spart_key_rx.sv
// tb_spart_key_rx: randomized scoreboard bench for spart_key_rx.
// Frames are driven bit by bit; a monitor checks every rx_vld pulse.
module tb_spart_key_rx;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       SPART_we;
  logic [3:0] SPART_keys;
  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_err;
  logic       busy;

  spart_key_rx #(.DIVISOR(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .SPART_we  (SPART_we),
    .SPART_keys(SPART_keys),
    .rx_byte   (rx_byte),
    .rx_vld    (rx_vld),
    .rx_err    (rx_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic       m;
    logic [3:0] k;
    int         t0;
  } exp_t;

  exp_t       q[$];
  logic [4:0] keymap[256];
  logic [3:0] mkeys;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic push(input logic [7:0] b, input int t0);
    exp_t e;
    if (keymap[b][4]) mkeys = keymap[b][3:0];
    e.b  = b;
    e.m  = keymap[b][4];
    e.k  = mkeys;
    e.t0 = t0;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic stop,
                      input logic lat);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) push(b, lat ? cyc : -1);
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (D) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rx_vld || SPART_we) begin
      if (!rx_vld) begin
        checks++;
        errors++;
        $display("FAIL we_without_vld keys=%0h", SPART_keys);
      end else if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vld byte=%0h we=%0b", rx_byte, SPART_we);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rx_byte", rx_byte, e.b);
        chk("spart_we", SPART_we, e.m);
        chk("spart_keys", SPART_keys, e.k);
        chk("rx_err_on_vld", rx_err, 0);
        if (e.t0 >= 0) begin
          checks++;
          if (cyc - e.t0 < 78 || cyc - e.t0 > 80) begin
            errors++;
            $display("FAIL latency actual=%0d expected=79+-1", cyc - e.t0);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] keys_tbl[9];
    logic [9:0] f;
    int         w;
    keys_tbl = '{8'h77, 8'h57, 8'h73, 8'h53, 8'h61, 8'h41, 8'h64, 8'h44,
                 8'h20};
    for (int i = 0; i < 256; i++) keymap[i] = 5'h00;
    keymap[8'h77] = 5'h11; keymap[8'h57] = 5'h11;
    keymap[8'h73] = 5'h12; keymap[8'h53] = 5'h12;
    keymap[8'h61] = 5'h14; keymap[8'h41] = 5'h14;
    keymap[8'h64] = 5'h18; keymap[8'h44] = 5'h18;
    keymap[8'h20] = 5'h1F;
    mkeys = 4'h0;

    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_we", SPART_we, 0);
    chk("rst_keys", SPART_keys, 0);
    chk("rst_byte", rx_byte, 0);
    chk("rst_vld", rx_vld, 0);
    chk("rst_err", rx_err, 0);
    chk("rst_busy", busy, 0);
    idle(20);
    chk("idle_busy", busy, 0);

    send(8'h77, 1'b1, 1'b1);
    chk("w_keys", SPART_keys, 4'h1);
    chk("w_byte", rx_byte, 8'h77);
    idle(4);

    send(8'h61, 1'b1, 1'b0);
    send(8'h44, 1'b1, 1'b0);
    send(8'h41, 1'b1, 1'b0);
    send(8'h5A, 1'b1, 1'b0);
    chk("b2b_keys", SPART_keys, 4'h4);
    chk("b2b_byte", rx_byte, 8'h5A);
    idle(4);

    rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(20);
    chk("glitch_busy", busy, 0);
    chk("glitch_err", rx_err, 0);

    send(8'h20, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("brk_err", rx_err, 1);
    chk("brk_busy", busy, 1);
    idle(4);
    chk("brk_exit_busy", busy, 0);
    chk("brk_exit_err", rx_err, 1);
    send(8'h20, 1'b1, 1'b0);
    chk("fire_keys", SPART_keys, 4'hF);
    chk("fire_err", rx_err, 0);
    idle(4);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      if ($urandom_range(0, 1) == 1) b = keys_tbl[$urandom_range(0, 8)];
      else b = 8'($urandom);
      send(b, 1'b1, 1'b0);
      idle($urandom_range(0, 15));
    end
    idle(2 * D);

    // Abort 's' during data bit 4; its trailing 0 bit then looks like a start.
    f = {1'b1, 8'h73, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      for (int c = 0; c < D; c++) begin
        rst = (i == 5 && c == 3);
        @(posedge clk);
        #1;
        if (i == 5 && c == 3) begin
          rst = 1'b0;
          chk("midrst_busy", busy, 0);
          chk("midrst_byte", rx_byte, 0);
          chk("midrst_keys", SPART_keys, 0);
          mkeys = 4'h0;
          push(8'hFF, -1);
        end
      end
    end
    rst = 1'b0;
    idle(12 * D);
    send(8'h73, 1'b1, 1'b0);
    chk("s_keys", SPART_keys, 4'h2);

    w = 0;
    while (q.size() != 0 && w < 20 * D) begin
      @(posedge clk);
      w++;
    end
    #1;
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_vld actual=none expected=%0h", e.b);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
